// File: rtl/rob_commit_if.sv
// Bundle between the ROB head, the commit stage and the architectural state.
// Handshake: st_req rises with st_addr/st_data valid and holds them stable until a cycle with st_ack=1.
interface rob_commit_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  logic              stall;
  logic              head_valid;
  logic [DATA_W-1:0] head_val;
  logic [4:0]        head_rd;
  logic              head_store;
  logic [DATA_W-1:0] head_addr;
  logic              head_ex;
  logic [DATA_W-1:0] head_pc;
  logic              head_pop;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              st_req;
  logic [DATA_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ack;
  logic              flush;
  logic [DATA_W-1:0] epc;
  logic [CNT_W-1:0]  retired;

  modport master (
    output stall, head_valid, head_val, head_rd, head_store, head_addr, head_ex, head_pc, st_ack,
    input  head_pop, rf_we, rf_waddr, rf_wdata, st_req, st_addr, st_data, flush, epc, retired
  );

  modport slave (
    input  stall, head_valid, head_val, head_rd, head_store, head_addr, head_ex, head_pc, st_ack,
    output head_pop, rf_we, rf_waddr, rf_wdata, st_req, st_addr, st_data, flush, epc, retired
  );
endinterface

// File: rtl/rob_commit.sv
// ROB commit stage: retires the head entry in order to the register file or data memory,
// and turns an excepting head into a flush pulse plus a recorded EPC.
module rob_commit #(
  parameter int DATA_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  rob_commit_if.slave bus,
  output logic [1:0] o_dbg_state
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STORE = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [FC_W-1:0]   r_fcnt;
  logic              r_rf_we;
  logic [4:0]        r_rf_waddr;
  logic [DATA_W-1:0] r_rf_wdata;
  logic [DATA_W-1:0] r_st_addr;
  logic [DATA_W-1:0] r_st_data;
  logic              r_flush;
  logic [DATA_W-1:0] r_epc;
  logic [CNT_W-1:0]  r_retired;

  logic w_go;
  logic w_pop;
  logic w_take_rf;
  logic w_take_st;
  logic w_take_ex;

  assign w_go = bus.head_valid & ~bus.stall;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_take_rf   = 1'b0;
    w_take_st   = 1'b0;
    w_take_ex   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_go) begin
          // An exception outranks the store flag: a faulting store must not reach memory.
          if (bus.head_ex) begin
            w_take_ex   = 1'b1;
            w_state_nxt = S_FLUSH;
          end else if (bus.head_store) begin
            w_take_st   = 1'b1;
            w_state_nxt = S_STORE;
          end else begin
            w_take_rf = 1'b1;
            w_pop     = 1'b1;
          end
        end
      end
      S_STORE: begin
        if (bus.st_ack) begin
          w_pop       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (r_fcnt == '0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_fcnt     <= '0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_st_addr  <= '0;
      r_st_data  <= '0;
      r_flush    <= 1'b0;
      r_epc      <= '0;
      r_retired  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rf_we <= w_take_rf && (bus.head_rd != 5'd0);
      if (w_take_rf && (bus.head_rd != 5'd0)) begin
        r_rf_waddr <= bus.head_rd;
        r_rf_wdata <= bus.head_val;
      end
      if (w_take_st) begin
        r_st_addr <= bus.head_addr;
        r_st_data <= bus.head_val;
      end
      r_flush <= w_take_ex;
      if (w_take_ex) r_epc <= bus.head_pc;
      // The flush-pulse cycle is the first of the FLUSH_CYCLES spent in FLUSH.
      if (w_take_ex) r_fcnt <= FC_W'(FLUSH_CYCLES - 1);
      else if ((r_state == S_FLUSH) && (r_fcnt != '0)) r_fcnt <= r_fcnt - FC_W'(1);
      if (w_pop) r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign bus.head_pop = w_pop;
  assign bus.rf_we    = r_rf_we;
  assign bus.rf_waddr = r_rf_waddr;
  assign bus.rf_wdata = r_rf_wdata;
  assign bus.st_req   = (r_state == S_STORE);
  assign bus.st_addr  = r_st_addr;
  assign bus.st_data  = r_st_data;
  assign bus.flush    = r_flush;
  assign bus.epc      = r_epc;
  assign bus.retired  = r_retired;
  assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed steps followed by random traffic, all checked against
// a transaction-level model of the commit rules.
module tb_rob_commit;
  localparam int DATA_W       = 32;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 32;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  rob_commit_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  rob_commit #(.DATA_W(DATA_W), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pops_seen = 0;
  int rf_we_seen = 0;

  // reference model: pending store, remaining flush cycles, expected registered outputs
  bit                m_st_pend;
  int                m_flush_left;
  bit                m_rf_we;
  logic [4:0]        m_rf_waddr;
  logic [DATA_W-1:0] m_rf_wdata;
  logic [DATA_W-1:0] m_st_addr;
  logic [DATA_W-1:0] m_st_data;
  bit                m_flush;
  logic [DATA_W-1:0] m_epc;
  logic [CNT_W-1:0]  m_retired;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st_pend = 0; m_flush_left = 0; m_rf_we = 0; m_rf_waddr = '0; m_rf_wdata = '0;
    m_st_addr = '0; m_st_data = '0; m_flush = 0; m_epc = '0; m_retired = '0;
  endtask

  function automatic bit exp_pop();
    if (m_st_pend) return bus.st_ack;
    if (m_flush_left > 0) return 1'b0;
    return bus.head_valid && !bus.stall && !bus.head_ex && !bus.head_store;
  endfunction

  task automatic model_check();
    logic [1:0] exp_state;
    exp_state = m_st_pend ? 2'd1 : ((m_flush_left > 0) ? 2'd2 : 2'd0);
    check("head_pop", {63'd0, bus.head_pop}, {63'd0, exp_pop()});
    check("rf_we",    {63'd0, bus.rf_we},    {63'd0, m_rf_we});
    check("rf_waddr", {59'd0, bus.rf_waddr}, {59'd0, m_rf_waddr});
    check("rf_wdata", 64'(bus.rf_wdata), 64'(m_rf_wdata));
    check("st_req",   {63'd0, bus.st_req},   {63'd0, m_st_pend});
    check("st_addr",  64'(bus.st_addr), 64'(m_st_addr));
    check("st_data",  64'(bus.st_data), 64'(m_st_data));
    check("flush",    {63'd0, bus.flush},    {63'd0, m_flush});
    check("epc",      64'(bus.epc), 64'(m_epc));
    check("retired",  64'(bus.retired), 64'(m_retired));
    check("state",    {62'd0, dbg_state},    {62'd0, exp_state});
    if (bus.head_pop) pops_seen++;
    if (bus.rf_we) rf_we_seen++;
  endtask

  task automatic model_advance();
    bit go;
    go = bus.head_valid && !bus.stall;
    m_rf_we = 0;
    m_flush = 0;
    if (m_st_pend) begin
      if (bus.st_ack) begin
        m_st_pend = 0;
        m_retired = m_retired + 1;
      end
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (go) begin
      if (bus.head_ex) begin
        m_flush = 1; m_epc = bus.head_pc; m_flush_left = FLUSH_CYCLES;
      end else if (bus.head_store) begin
        m_st_pend = 1; m_st_addr = bus.head_addr; m_st_data = bus.head_val;
      end else begin
        m_retired = m_retired + 1;
        if (bus.head_rd != 0) begin
          m_rf_we = 1; m_rf_waddr = bus.head_rd; m_rf_wdata = bus.head_val;
        end
      end
    end
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk);
    model_check();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_head(input bit v, input logic [4:0] rd, input logic [DATA_W-1:0] val,
                          input bit st, input logic [DATA_W-1:0] addr, input bit ex,
                          input logic [DATA_W-1:0] pc);
    bus.head_valid = v; bus.head_rd = rd; bus.head_val = val;
    bus.head_store = st; bus.head_addr = addr; bus.head_ex = ex; bus.head_pc = pc;
  endtask

  initial begin
    int p0;
    int w0;
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.st_ack = 1'b0;
    set_head(0, 5'd0, '0, 0, '0, 0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_check();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single register retirement
    set_head(1, 5'd5, 32'hDEADBEEF, 0, '0, 0, '0);
    tick();
    set_head(0, 5'd0, '0, 0, '0, 0, '0);
    check("tp1_rf_we", {63'd0, bus.rf_we}, 64'd1);
    check("tp1_rf_wdata", 64'(bus.rf_wdata), 64'hDEADBEEF);
    check("tp1_retired", 64'(bus.retired), 64'd1);
    tick();

    // back-to-back rd=1,2,0
    p0 = pops_seen; w0 = rf_we_seen;
    set_head(1, 5'd1, 32'h11, 0, '0, 0, '0); tick();
    set_head(1, 5'd2, 32'h22, 0, '0, 0, '0); tick();
    set_head(1, 5'd0, 32'h33, 0, '0, 0, '0); tick();
    set_head(0, 5'd0, '0, 0, '0, 0, '0); tick();
    check("tp2_pops", 64'(pops_seen - p0), 64'd3);
    check("tp2_rf_we_pulses", 64'(rf_we_seen - w0), 64'd2);
    check("tp2_retired", 64'(bus.retired), 64'd4);

    // store with delayed ack, stall toggling during the wait
    p0 = pops_seen;
    set_head(1, 5'd9, 32'h55, 1, 32'h100, 0, '0);
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.stall = i[0];
      bus.st_ack = (i == 3);
      check("tp3_st_req", {63'd0, bus.st_req}, 64'd1);
      check("tp3_st_addr", 64'(bus.st_addr), 64'h100);
      tick();
    end
    set_head(0, 5'd0, '0, 0, '0, 0, '0);
    bus.stall = 1'b0; bus.st_ack = 1'b0;
    check("tp3_pops", 64'(pops_seen - p0), 64'd1);
    check("tp3_retired", 64'(bus.retired), 64'd5);
    tick();

    // exception on a store, then flush window, then a normal retirement
    set_head(1, 5'd0, 32'hAA, 1, 32'h200, 1, 32'h40);
    tick();
    check("tp4_flush", {63'd0, bus.flush}, 64'd1);
    check("tp4_epc", 64'(bus.epc), 64'h40);
    set_head(1, 5'd7, 32'h77, 0, '0, 0, 32'h44);
    tick();
    check("tp4_flush_pulse_end", {63'd0, bus.flush}, 64'd0);
    tick();
    tick();
    set_head(0, 5'd0, '0, 0, '0, 0, '0);
    check("tp4_retire_after_flush", 64'(bus.retired), 64'd6);
    check("tp4_rf_waddr", {59'd0, bus.rf_waddr}, 64'd7);
    tick();

    // stall holds off retirement
    p0 = pops_seen;
    set_head(1, 5'd3, 32'h3333, 0, '0, 0, '0);
    bus.stall = 1'b1;
    repeat (4) tick();
    check("tp5_no_pop_in_stall", 64'(pops_seen - p0), 64'd0);
    bus.stall = 1'b0;
    tick();
    set_head(0, 5'd0, '0, 0, '0, 0, '0);
    check("tp5_pop_on_release", 64'(pops_seen - p0), 64'd1);
    tick();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      set_head($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), $urandom,
               $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 9) == 0, $urandom);
      bus.stall  = $urandom_range(0, 4) == 0;
      bus.st_ack = $urandom_range(0, 9) < 4;
      tick();
    end

    // drain to idle, then reset in the middle of a store
    set_head(0, 5'd0, '0, 0, '0, 0, '0);
    bus.stall = 1'b0; bus.st_ack = 1'b1;
    repeat (4) tick();
    bus.st_ack = 1'b0;
    set_head(1, 5'd0, 32'hCAFE, 1, 32'h300, 0, '0);
    tick();
    set_head(0, 5'd0, '0, 0, '0, 0, '0);
    check("tp6_st_req_before_rst", {63'd0, bus.st_req}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("tp6_st_req_async_drop", {63'd0, bus.st_req}, 64'd0);
    check("tp6_retired_cleared", 64'(bus.retired), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    check("tp6_state_idle", {62'd0, dbg_state}, 64'd0);
    set_head(1, 5'd4, 32'h4444, 0, '0, 0, '0);
    tick();
    set_head(0, 5'd0, '0, 0, '0, 0, '0);
    tick();

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
